serial_add_sub: RTL and testbench

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

---
 rtl/serial_add_sub.sv | 143 ++++++++++++++
 tb/tb_serial_add_sub.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, ripple carry/borrow held in a flop.
// Latency: start at edge k -> done during the cycle after edge k+WIDTH; back to IDLE one edge later.
// Backpressure: none; start is only accepted in IDLE and is ignored while busy or done.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    // Counter must index bits 0..WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_a;
    logic             bit_b;
    logic             bit_out;
    logic             c_next;
    logic [WIDTH-1:0] shifted;

    // Single-bit full adder / full subtractor for the bit selected by the counter.
    always_comb begin
        bit_a = a_q[cnt_q];
        bit_b = b_q[cnt_q];
        bit_out = bit_a ^ bit_b ^ c_q;
        if (mode_q) begin
            c_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & c_q);
        end else begin
            c_next = (bit_a & bit_b) | (bit_a & c_q) | (bit_b & c_q);
        end
        // New bit enters at the MSB; after WIDTH shifts bit 0 has reached position 0.
        shifted = result_q >> 1;
        shifted[WIDTH-1] = bit_out;
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        result_d = result_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    mode_d   = mode;
                    c_d      = 1'b0;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d = shifted;
                c_d      = c_next;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    cout_d  = c_next;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // All state, including the registered busy/done outputs, clears asynchronously on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: WIDTH=8 vector table and corner sequences, WIDTH=3 exhaustive sweep.
// Expected results are queued when an operation is issued and checked when done pulses.
// Outputs are sampled on the falling clock edge; inputs change on the falling edge as well.
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0, mode8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] result8;

    logic       start3 = 1'b0, mode3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       busy3, done3, cout3;
    logic [2:0] result3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        c;
    } exp_t;

    typedef struct {
        logic        mode;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  res;
        logic        c;
    } vec_t;

    exp_t q8[$];
    exp_t q3[$];

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .cout(cout8)
    );

    serial_add_sub #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .result(result3), .cout(cout3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                chk("w8 unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8 result", {24'd0, result8}, e.res);
                chk("w8 cout", {31'd0, cout8}, {31'd0, e.c});
            end
        end
        if (done3) begin
            if (q3.size() == 0) begin
                chk("w3 unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("w3 result", {29'd0, result3}, e.res);
                chk("w3 cout", {31'd0, cout3}, {31'd0, e.c});
            end
        end
    end

    // Issue one operation from a falling edge, then watch busy/done until done appears.
    // Returns on the falling edge of the IDLE cycle so a following call is back-to-back.
    task automatic run_op(input bit w3, input logic m, input logic [7:0] av, input logic [7:0] bv,
                          input logic [31:0] er, input logic ec);
        exp_t e;
        int   lat;
        int   bc;
        int   w;
        e.res = er;
        e.c   = ec;
        w     = w3 ? 3 : 8;
        if (w3) begin
            start3 = 1'b1; mode3 = m; a3 = av[2:0]; b3 = bv[2:0];
            q3.push_back(e);
        end else begin
            start8 = 1'b1; mode8 = m; a8 = av; b8 = bv;
            q8.push_back(e);
        end
        @(negedge clk);
        start3 = 1'b0; start8 = 1'b0;
        // Scramble operands: they must not matter once the start edge has passed.
        a8 = 8'h5A; b8 = 8'hC3; mode8 = ~mode8;
        a3 = 3'h5;  b3 = 3'h6;  mode3 = ~mode3;
        lat = 0;
        bc  = 0;
        while (!(w3 ? done3 : done8) && lat < 40) begin
            if (w3 ? busy3 : busy8) bc++;
            lat++;
            @(negedge clk);
        end
        chk(w3 ? "w3 latency" : "w8 latency", lat, w);
        chk(w3 ? "w3 busy cycles" : "w8 busy cycles", bc, w);
        chk(w3 ? "w3 busy in done" : "w8 busy in done", {31'd0, w3 ? busy3 : busy8}, 32'd0);
        @(negedge clk);
        chk(w3 ? "w3 done pulse width" : "w8 done pulse width", {31'd0, w3 ? done3 : done8}, 32'd0);
    endtask

    initial begin
        vec_t vt[9];
        int   dn;

        vt[0] = '{1'b0, 8'd100, 8'd27,  8'd127, 1'b0};
        vt[1] = '{1'b0, 8'd200, 8'd100, 8'd44,  1'b1};
        vt[2] = '{1'b1, 8'd5,   8'd7,   8'd254, 1'b1};
        vt[3] = '{1'b1, 8'd7,   8'd5,   8'd2,   1'b0};
        vt[4] = '{1'b0, 8'd255, 8'd1,   8'd0,   1'b1};
        vt[5] = '{1'b1, 8'd0,   8'd0,   8'd0,   1'b0};
        vt[6] = '{1'b0, 8'd0,   8'd0,   8'd0,   1'b0};
        vt[7] = '{1'b1, 8'd128, 8'd255, 8'd129, 1'b1};
        vt[8] = '{1'b0, 8'd85,  8'd170, 8'd255, 1'b0};

        // Reset state, checked before any clock edge.
        #2;
        chk("rst busy", {31'd0, busy8}, 32'd0);
        chk("rst done", {31'd0, done8}, 32'd0);
        chk("rst result", {24'd0, result8}, 32'd0);
        chk("rst cout", {31'd0, cout8}, 32'd0);

        // start during reset is ignored.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
        @(negedge clk);
        chk("start under rst", {31'd0, busy8}, 32'd0);
        start8 = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Vector table, issued back-to-back.
        for (int i = 0; i < 9; i++) begin
            run_op(1'b0, vt[i].mode, vt[i].a, vt[i].b, {24'd0, vt[i].res}, vt[i].c);
        end

        // start pulsed mid-operation must be ignored.
        @(negedge clk);
        q8.push_back('{32'd0, 1'b0});
        start8 = 1'b1; mode8 = 1'b1; a8 = 8'd0; b8 = 8'd0;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'd1; b8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) dn++;
            @(negedge clk);
        end
        chk("ignored start done count", dn, 1);

        // Asynchronous reset three cycles into an add aborts it.
        q8.push_back('{32'd255, 1'b0});
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'd255; b8 = 8'd0;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy before abort", {31'd0, busy8}, 32'd1);
        chk("partial result nonzero", {31'd0, result8 != 8'd0}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", {31'd0, busy8}, 32'd0);
        chk("abort done", {31'd0, done8}, 32'd0);
        chk("abort result", {24'd0, result8}, 32'd0);
        chk("abort cout", {31'd0, cout8}, 32'd0);
        q8.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) @(negedge clk);
        run_op(1'b0, 1'b0, 8'd3, 8'd4, 32'd7, 1'b0);

        // WIDTH=3 exhaustive sweep against an integer reference.
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 8; x++) begin
                for (int y = 0; y < 8; y++) begin
                    int   r;
                    logic c;
                    if (m == 0) begin
                        r = (x + y) & 7;
                        c = ((x + y) > 7);
                    end else begin
                        r = (x - y) & 7;
                        c = (x < y);
                    end
                    run_op(1'b1, m[0], x[7:0], y[7:0], r, c);
                end
            end
        end

        @(negedge clk);
        chk("w8 queue drained", q8.size(), 0);
        chk("w3 queue drained", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
